// File: rtl/cmd_pkg.sv
// Shared types and constants for the command dispatcher.
package cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_RESP
  } state_t;

  // Response status codes, zero-extended to the word width at the use site.
  localparam int STATUS_OK      = 0;
  localparam int STATUS_BADCMD  = 1;
  localparam int STATUS_TIMEOUT = 2;

  // Default ASCII command codes.
  localparam logic [7:0] DEF_READ_CMD  = 8'h72;  // 'r'
  localparam logic [7:0] DEF_WRITE_CMD = 8'h77;  // 'w'
  localparam logic [7:0] DEF_SET_CMD   = 8'h73;  // 's'
  localparam logic [7:0] DEF_CLR_CMD   = 8'h63;  // 'c'

endpackage

// File: rtl/cmd_timeout_counter.sv
// Counts consecutive read-wait cycles; expired marks the final allowed cycle.
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins; otherwise count up while enabled and saturate at the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // High during the TIMEOUT_CYCLES-th enabled cycle.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cmd_dispatcher.sv
// Command frame dispatcher: write / read / read-modify-write to a register bank
// with read timeout and a held status+data response.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int WORD_WIDTH     = 8,
  parameter int ADDR_WORDS     = 1,
  parameter int VALUE_WORDS    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [WORD_WIDTH-1:0] READ_CMD  = WORD_WIDTH'(DEF_READ_CMD),
  parameter logic [WORD_WIDTH-1:0] WRITE_CMD = WORD_WIDTH'(DEF_WRITE_CMD),
  parameter logic [WORD_WIDTH-1:0] SET_CMD   = WORD_WIDTH'(DEF_SET_CMD),
  parameter logic [WORD_WIDTH-1:0] CLR_CMD   = WORD_WIDTH'(DEF_CLR_CMD),
  localparam int ADDR_W  = WORD_WIDTH * ADDR_WORDS,
  localparam int VAL_W   = WORD_WIDTH * VALUE_WORDS,
  localparam int FRAME_W = WORD_WIDTH + ADDR_W + VAL_W
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic [FRAME_W-1:0]          i_data,
  input  logic                        i_dv,
  output logic                        o_ready,
  output logic                        o_drop,
  output logic                        o_w_en,
  output logic                        o_r_en,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [VAL_W-1:0]            o_value,
  input  logic [VAL_W-1:0]            i_r_data,
  input  logic                        i_r_valid,
  output logic [WORD_WIDTH+VAL_W-1:0] o_resp_data,
  output logic                        o_resp_valid,
  input  logic                        i_resp_ready
);

  localparam logic [WORD_WIDTH-1:0] ST_OK      = WORD_WIDTH'(STATUS_OK);
  localparam logic [WORD_WIDTH-1:0] ST_BADCMD  = WORD_WIDTH'(STATUS_BADCMD);
  localparam logic [WORD_WIDTH-1:0] ST_TIMEOUT = WORD_WIDTH'(STATUS_TIMEOUT);

  state_t                        state_q, state_d;
  logic [WORD_WIDTH-1:0]         cmd_q, cmd_d;
  logic [VAL_W-1:0]              opnd_q, opnd_d;   // latched frame value (RMW mask)
  logic                          ready_q, ready_d;
  logic                          drop_q, drop_d;
  logic                          w_en_q, w_en_d;
  logic                          r_en_q, r_en_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [VAL_W-1:0]              value_q, value_d;
  logic [WORD_WIDTH+VAL_W-1:0]   resp_q, resp_d;
  logic                          rvld_q, rvld_d;
  logic                          expired;

  wire [WORD_WIDTH-1:0] f_cmd   = i_data[FRAME_W-1 -: WORD_WIDTH];
  wire [ADDR_W-1:0]     f_addr  = i_data[ADDR_W+VAL_W-1 -: ADDR_W];
  wire [VAL_W-1:0]      f_value = i_data[VAL_W-1:0];

  // Counter runs only in READ_WAIT and is held clear everywhere else.
  cmd_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (clk),
    .rst_ni    (i_reset_n),
    .clr_i     (state_q != S_READ_WAIT),
    .en_i      (state_q == S_READ_WAIT),
    .expired_o (expired)
  );

  // Next-state and registered-output decode; everything holds unless changed below.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    opnd_d  = opnd_q;
    ready_d = ready_q;
    drop_d  = i_dv && !ready_q;
    w_en_d  = 1'b0;
    r_en_d  = 1'b0;
    addr_d  = addr_q;
    value_d = value_q;
    resp_d  = resp_q;
    rvld_d  = rvld_q;
    unique case (state_q)
      S_IDLE: if (i_dv && ready_q) begin
        cmd_d   = f_cmd;
        opnd_d  = f_value;
        ready_d = 1'b0;
        if (f_cmd == WRITE_CMD) begin
          addr_d  = f_addr;
          value_d = f_value;
          w_en_d  = 1'b1;
          state_d = S_WRITE;
        end else if (f_cmd == READ_CMD || f_cmd == SET_CMD || f_cmd == CLR_CMD) begin
          addr_d  = f_addr;
          r_en_d  = 1'b1;
          state_d = S_READ_REQ;
        end else begin
          resp_d  = {ST_BADCMD, {VAL_W{1'b0}}};
          rvld_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      // Strobe was issued on entry; report the value that was written.
      S_WRITE: begin
        resp_d  = {ST_OK, value_q};
        rvld_d  = 1'b1;
        state_d = S_RESP;
      end
      S_READ_REQ: state_d = S_READ_WAIT;
      // Data arriving in the final cycle takes priority over the timeout.
      S_READ_WAIT: begin
        if (i_r_valid) begin
          if (cmd_q == SET_CMD || cmd_q == CLR_CMD) begin
            value_d = (cmd_q == SET_CMD) ? (i_r_data | opnd_q) : (i_r_data & ~opnd_q);
            w_en_d  = 1'b1;
            state_d = S_WRITE;
          end else begin
            resp_d  = {ST_OK, i_r_data};
            rvld_d  = 1'b1;
            state_d = S_RESP;
          end
        end else if (expired) begin
          resp_d  = {ST_TIMEOUT, {VAL_W{1'b0}}};
          rvld_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (i_resp_ready) begin
        rvld_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        rvld_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves only o_ready high.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      opnd_q  <= '0;
      ready_q <= 1'b1;
      drop_q  <= 1'b0;
      w_en_q  <= 1'b0;
      r_en_q  <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
      resp_q  <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      opnd_q  <= opnd_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
      w_en_q  <= w_en_d;
      r_en_q  <= r_en_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      resp_q  <= resp_d;
      rvld_q  <= rvld_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_drop       = drop_q;
  assign o_w_en       = w_en_q;
  assign o_r_en       = r_en_q;
  assign o_addr       = addr_q;
  assign o_value      = value_q;
  assign o_resp_data  = resp_q;
  assign o_resp_valid = rvld_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher (TIMEOUT_CYCLES = 8).
module tb_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [47:0] i_data;
  logic        i_dv;
  logic        o_ready, o_drop, o_w_en, o_r_en;
  logic [7:0]  o_addr;
  logic [31:0] o_value;
  logic [31:0] i_r_data;
  logic        i_r_valid;
  logic [39:0] o_resp_data;
  logic        o_resp_valid;
  logic        i_resp_ready;

  cmd_dispatcher #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .i_data       (i_data),
    .i_dv         (i_dv),
    .o_ready      (o_ready),
    .o_drop       (o_drop),
    .o_w_en       (o_w_en),
    .o_r_en       (o_r_en),
    .o_addr       (o_addr),
    .o_value      (o_value),
    .i_r_data     (i_r_data),
    .i_r_valid    (i_r_valid),
    .o_resp_data  (o_resp_data),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [7:0] addr; logic [31:0] val; int cyc; } strb_t;
  typedef struct { logic [39:0] d; int cyc; } rsp_t;
  strb_t sq[$];
  rsp_t  rq[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_s(input logic we, input logic [7:0] a, input logic [31:0] v, input int c);
    strb_t s;
    s.we = we; s.addr = a; s.val = v; s.cyc = c;
    sq.push_back(s);
  endtask

  task automatic push_r(input logic [39:0] d, input int c);
    rsp_t r;
    r.d = d; r.cyc = c;
    rq.push_back(r);
  endtask

  // Strobe and response monitor, sampling on the falling edge.
  strb_t       ms;
  rsp_t        mr;
  logic        ract = 1'b0;
  logic [39:0] held;
  always @(negedge clk) begin
    if (!i_reset_n) ract = 1'b0;
    else begin
      if (o_w_en || o_r_en) begin
        chk("strobe_excl", {63'b0, o_w_en & o_r_en}, 64'd0);
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL strobe_unexp: got w=%0b r=%0b addr=%h expected none", o_w_en, o_r_en, o_addr);
        end else begin
          ms = sq.pop_front();
          chk("strobe_we", {63'b0, o_w_en}, {63'b0, ms.we});
          chk("strobe_addr", {56'b0, o_addr}, {56'b0, ms.addr});
          if (ms.we) chk("strobe_val", {32'b0, o_value}, {32'b0, ms.val});
          chk("strobe_cyc", 64'(cyc), 64'(ms.cyc));
        end
      end
      if (o_resp_valid) begin
        if (!ract) begin
          ract = 1'b1;
          held = o_resp_data;
          if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL resp_unexp: got %h expected none", o_resp_data);
          end else begin
            mr = rq.pop_front();
            chk("resp_data", {24'b0, o_resp_data}, {24'b0, mr.d});
            chk("resp_cyc", 64'(cyc), 64'(mr.cyc));
          end
        end else chk("resp_stable", {24'b0, o_resp_data}, {24'b0, held});
        if (i_resp_ready) ract = 1'b0;
      end
    end
  end

  // Present a frame once o_ready is seen; returns the accept edge number.
  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [31:0] v, output int n);
    int k = 0;
    while (!o_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!o_ready) chk("ready_wait", {63'b0, o_ready}, 64'd1);
    i_data = {c, a, v}; i_dv = 1'b1;
    @(posedge clk); #1;
    n = cyc; i_dv = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    int k = 0;
    while (cyc < c && k < 200) begin @(posedge clk); #1; k++; end
  endtask

  // Drive read data for one cycle starting after edge n+d (sampled at edge n+d+1).
  task automatic rvalid_at(input int n, input int d, input logic [31:0] data);
    wait_cyc(n + d);
    i_r_data = data; i_r_valid = 1'b1;
    @(posedge clk); #1;
    i_r_valid = 1'b0;
  endtask

  int n;
  initial begin
    i_reset_n = 1'b0; i_data = '0; i_dv = 1'b0;
    i_r_data = '0; i_r_valid = 1'b0; i_resp_ready = 1'b1;
    #12;
    chk("rst_ready", {63'b0, o_ready}, 64'd1);
    chk("rst_strobes", {62'b0, o_w_en, o_r_en}, 64'd0);
    chk("rst_resp", {23'b0, o_resp_valid, o_resp_data}, 64'd0);
    chk("rst_drop", {63'b0, o_drop}, 64'd0);
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    @(posedge clk); #1;

    // Plain write
    send(8'h77, 8'h21, 32'h87654321, n);
    push_s(1'b1, 8'h21, 32'h87654321, n);
    push_r({8'h00, 32'h87654321}, n + 1);

    // Read; a valid during READ_REQ must be ignored
    send(8'h72, 8'h12, 32'h0, n);
    push_s(1'b0, 8'h12, 32'h0, n);
    push_r({8'h00, 32'hDEADBEEF}, n + 3);
    rvalid_at(n, 0, 32'h11111111);
    rvalid_at(n, 2, 32'hDEADBEEF);

    // Set bits: 0F | F0
    send(8'h73, 8'h05, 32'h000000F0, n);
    push_s(1'b0, 8'h05, 32'h0, n);
    push_s(1'b1, 8'h05, 32'h000000FF, n + 3);
    push_r({8'h00, 32'h000000FF}, n + 4);
    rvalid_at(n, 2, 32'h0000000F);

    // Clear bits: FF & ~0F
    send(8'h63, 8'h06, 32'h0000000F, n);
    push_s(1'b0, 8'h06, 32'h0, n);
    push_s(1'b1, 8'h06, 32'h000000F0, n + 3);
    push_r({8'h00, 32'h000000F0}, n + 4);
    rvalid_at(n, 2, 32'h000000FF);

    // Read timeout, plus a frame offered while busy
    send(8'h72, 8'h30, 32'h0, n);
    push_s(1'b0, 8'h30, 32'h0, n);
    push_r({8'h02, 32'h0}, n + 9);
    i_data = {8'h77, 8'h99, 32'h55555555}; i_dv = 1'b1;
    @(posedge clk); #1;
    chk("drop_pulse", {63'b0, o_drop}, 64'd1);
    i_dv = 1'b0;
    @(posedge clk); #1;
    chk("drop_end", {63'b0, o_drop}, 64'd0);

    // Set timing out: no write
    send(8'h73, 8'h31, 32'h00000001, n);
    push_s(1'b0, 8'h31, 32'h0, n);
    push_r({8'h02, 32'h0}, n + 9);

    // Valid on the 8th (final) wait cycle wins
    send(8'h72, 8'h32, 32'h0, n);
    push_s(1'b0, 8'h32, 32'h0, n);
    push_r({8'h00, 32'hCAFEF00D}, n + 9);
    rvalid_at(n, 8, 32'hCAFEF00D);

    // Unknown command
    send(8'h41, 8'h01, 32'h12345678, n);
    push_r({8'h01, 32'h0}, n);

    // Response held while consumer stalls
    wait_cyc(cyc + 3);
    i_resp_ready = 1'b0;
    send(8'h77, 8'h40, 32'hA5A5A5A5, n);
    push_s(1'b1, 8'h40, 32'hA5A5A5A5, n);
    push_r({8'h00, 32'hA5A5A5A5}, n + 1);
    wait_cyc(n + 6);
    chk("stall_ready", {63'b0, o_ready}, 64'd0);
    chk("stall_valid", {63'b0, o_resp_valid}, 64'd1);
    i_resp_ready = 1'b1;

    // Reset during READ_WAIT aborts the read
    send(8'h72, 8'h50, 32'h0, n);
    push_s(1'b0, 8'h50, 32'h0, n);
    wait_cyc(n + 4);
    #2 i_reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'b0, o_ready}, 64'd1);
    chk("mid_rst_out", {61'b0, o_w_en, o_r_en, o_resp_valid}, 64'd0);
    chk("mid_rst_addr", {56'b0, o_addr}, 64'd0);
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    i_r_data = 32'hBADBAD00; i_r_valid = 1'b1;
    @(posedge clk); #1;
    i_r_valid = 1'b0;
    wait_cyc(cyc + 12);
    chk("post_rst_idle", {62'b0, o_ready, o_resp_valid}, 64'd2);

    send(8'h77, 8'h51, 32'h12345678, n);
    push_s(1'b1, 8'h51, 32'h12345678, n);
    push_r({8'h00, 32'h12345678}, n + 1);
    wait_cyc(n + 6);

    chk("strobes_left", 64'(sq.size()), 64'd0);
    chk("resps_left", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
